rca_serial_sub: RTL

RCA_SERIAL_SUB -- requirements
Module: rca_serial_sub

---
 rtl/rca_serial_sub.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rca_serial_sub.sv
// rca_serial_sub: bit-serial ripple-borrow subtractor with a valid/ready handshake.
//
// Computes (A - B) mod 2^WIDTH one bit per cycle, LSB first, through a single
// full-subtractor cell and a borrow flop. A transaction is accepted in IDLE,
// takes WIDTH cycles in SHIFT, and its result is presented in DONE until the
// consumer takes it.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   operand pair on A/B is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   A          minuend, unsigned
//   B          subtrahend, unsigned
//   out_valid  diff/bout/ovf/zero hold a completed result (DONE only)
//   out_ready  consumer accepts the result
//   diff       (A - B) mod 2^WIDTH
//   bout       final borrow, 1 iff A < B unsigned
//   ovf        two's-complement overflow of A - B
//   zero       diff == 0
module rca_serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the low WIDTH-1 result bits collected so far; the final bit is
  // combined with it on the last SHIFT edge, so the visible diff only ever
  // changes to a complete result.
  logic [WIDTH-2:0] diff_sh;
  logic [CNT_W-1:0] cnt;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] diff_fin;

  function automatic logic sub_diff(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  function automatic logic sub_borrow(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  assign a_bit    = a_sh[0];
  assign b_bit    = b_sh[0];
  assign d_bit    = sub_diff(a_bit, b_bit, br);
  assign br_nxt   = sub_borrow(a_bit, b_bit, br);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign diff_fin = {d_bit, diff_sh};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers: loaded on accept, consumed LSB first
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_sh <= A;
      b_sh <= B;
    end else if (state == SHIFT) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= diff_fin[WIDTH-1:1];
    end
  end

  // Counter, borrow and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            br  <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          br  <= br_nxt;
          if (last_bit) begin
            // On the last bit a_bit/b_bit are the operand MSBs and d_bit is diff MSB.
            diff <= diff_fin;
            bout <= br_nxt;
            ovf  <= (a_bit != b_bit) && (d_bit != a_bit);
            zero <= (diff_fin == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
